fpu_issue_sched: RTL and testbench

- Single-issue FPU scheduler between the core's decode stage and the fadd_fsub, fmul and fdiv IP cores.
- Accepts one FPU-special instruction per cycle through a valid/ready handshake and starts the correct unit.
- Reserves the single freg write port at issue time, tracks pending destinations in a scoreboard, and stalls the core on hazards.
- Core FPU writes go only through this block's writeback port; the core stops writing freg_data directly.

---
 rtl/fpu_issue_sched.sv | 177 +++++++++++++++++
 tb/tb_fpu_issue_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_sched.sv
// Single-issue FPU scheduler: accepts decoded FPU ops, starts the matching unit,
// reserves the shared freg write port in a shift ring and tracks pending destinations.
module fpu_issue_sched #(
  parameter int unsigned ADD_LAT = 3,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 12,
  parameter int unsigned MAX_LAT = 12
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_funct,
  input  logic [4:0]  issue_fs,
  input  logic [4:0]  issue_ft,
  input  logic [4:0]  issue_fd,
  input  logic [31:0] mov_data,
  output logic        add_start,
  output logic        mul_start,
  output logic        div_start,
  output logic        add_sub,
  input  logic [31:0] add_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] div_result,
  output logic        wb_valid,
  output logic [4:0]  wb_idx,
  output logic [31:0] wb_data,
  output logic [31:0] busy_mask,
  output logic        illegal,
  output logic        idle
);

  localparam int unsigned IW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {SRC_ADD, SRC_MUL, SRC_DIV, SRC_MOV} src_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
    src_e       src;
  } slot_t;

  slot_t          ring_q  [MAX_LAT];
  slot_t          ring_sh [MAX_LAT];
  slot_t          ring_d  [MAX_LAT];
  logic [31:0]    busy_q;
  logic [31:0]    busy_d;
  logic [CW-1:0]  div_cnt_q;
  logic [31:0]    mov_q;
  logic           div_busy;

  logic           legal;
  logic           uses_fs;
  logic           is_div;
  src_e           op_src;
  logic [IW-1:0]  lat_m1;
  logic           slot_free;
  logic           hazard;
  logic           accept_op;
  logic           any_valid;
  logic [31:0]    wb_clr;
  logic [31:0]    issue_set;

  // Decode funct into latency, writeback source and operand usage.
  always_comb begin
    legal   = 1'b1;
    uses_fs = 1'b1;
    is_div  = 1'b0;
    op_src  = SRC_ADD;
    lat_m1  = '0;
    case (issue_funct)
      6'd0, 6'd1: begin
        op_src = SRC_ADD;
        lat_m1 = IW'(ADD_LAT - 1);
      end
      6'd2: begin
        op_src = SRC_MUL;
        lat_m1 = IW'(MUL_LAT - 1);
      end
      6'd3: begin
        op_src = SRC_DIV;
        lat_m1 = IW'(DIV_LAT - 1);
        is_div = 1'b1;
      end
      6'd6: begin
        op_src  = SRC_MOV;
        lat_m1  = '0;
        uses_fs = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // Ring as it will look after this cycle's shift, before inserting the new op.
  always_comb begin
    for (int k = 0; k < int'(MAX_LAT) - 1; k++) begin
      ring_sh[k] = ring_q[k+1];
    end
    ring_sh[MAX_LAT-1] = '0;
  end

  assign div_busy  = (div_cnt_q != '0);
  assign slot_free = ~ring_sh[lat_m1].valid;
  assign hazard    = busy_q[issue_ft] | busy_q[issue_fd] | (uses_fs & busy_q[issue_fs]);

  assign issue_ready = ~legal | (slot_free & ~hazard & ~(is_div & div_busy));
  assign accept_op   = issue_valid & issue_ready & legal;

  assign add_start = accept_op & (op_src == SRC_ADD);
  assign mul_start = accept_op & (op_src == SRC_MUL);
  assign div_start = accept_op & (op_src == SRC_DIV);
  assign add_sub   = issue_funct[0];
  assign illegal   = issue_valid & ~legal;

  always_comb begin
    for (int k = 0; k < int'(MAX_LAT); k++) begin
      ring_d[k] = ring_sh[k];
    end
    if (accept_op) begin
      ring_d[lat_m1] = '{valid: 1'b1, idx: issue_fd, src: op_src};
    end
  end

  // Writeback is driven straight from the head of the ring.
  assign wb_valid = ring_q[0].valid;
  assign wb_idx   = ring_q[0].idx;

  always_comb begin
    case (ring_q[0].src)
      SRC_ADD: wb_data = add_result;
      SRC_MUL: wb_data = mul_result;
      SRC_DIV: wb_data = div_result;
      default: wb_data = mov_q;
    endcase
  end

  // A new reservation on the same index overrides the retiring one.
  assign wb_clr    = wb_valid ? (32'd1 << wb_idx) : 32'd0;
  assign issue_set = accept_op ? (32'd1 << issue_fd) : 32'd0;
  assign busy_d    = (busy_q & ~wb_clr) | issue_set;
  assign busy_mask = busy_q;

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < int'(MAX_LAT); k++) begin
      any_valid = any_valid | ring_q[k].valid;
    end
  end

  assign idle = ~any_valid & ~div_busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < int'(MAX_LAT); k++) begin
        ring_q[k] <= '0;
      end
      busy_q    <= '0;
      div_cnt_q <= '0;
      mov_q     <= '0;
    end else begin
      for (int k = 0; k < int'(MAX_LAT); k++) begin
        ring_q[k] <= ring_d[k];
      end
      busy_q <= busy_d;
      if (div_start) begin
        div_cnt_q <= CW'(DIV_LAT - 1);
      end else if (div_busy) begin
        div_cnt_q <= div_cnt_q - CW'(1);
      end
      if (accept_op && (op_src == SRC_MOV)) begin
        mov_q <= mov_data;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: cycle-level model of pending writebacks plus directed
// scenarios with hand-computed acceptance cycles and writeback values.
module tb_fpu_issue_sched;

  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 12;

  logic        CLK;
  logic        RST_N;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_funct;
  logic [4:0]  issue_fs, issue_ft, issue_fd;
  logic [31:0] mov_data;
  logic        add_start, mul_start, div_start, add_sub;
  logic [31:0] add_result, mul_result, div_result;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;
  logic        illegal;
  logic        idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fpu_issue_sched #(.ADD_LAT(3), .MUL_LAT(2), .DIV_LAT(12), .MAX_LAT(12)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_funct(issue_funct),
    .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd), .mov_data(mov_data),
    .add_start(add_start), .mul_start(mul_start), .div_start(div_start), .add_sub(add_sub),
    .add_result(add_result), .mul_result(mul_result), .div_result(div_result),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .busy_mask(busy_mask), .illegal(illegal), .idle(idle)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Unit outputs change every cycle so a wrong mux or timing shows up in wb_data.
  assign add_result = 32'hA000_0000 + 32'(cyc);
  assign mul_result = 32'hB000_0000 + 32'(cyc);
  assign div_result = 32'hD000_0000 + 32'(cyc);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [5:0] f);
    case (f)
      6'd0, 6'd1: return ADD_LAT;
      6'd2:       return MUL_LAT;
      6'd3:       return DIV_LAT;
      6'd6:       return 1;
      default:    return 0;
    endcase
  endfunction

  // Model: list of accepted ops with their acceptance and writeback cycles.
  typedef struct {
    int          acc;
    int          wb;
    logic [4:0]  idx;
    int          src;
    logic [31:0] mdat;
  } pend_t;

  pend_t       pend[$];
  pend_t       keep[$];
  pend_t       ew;
  pend_t       np;
  bit          div_seen = 0;
  int          div_last = 0;
  logic [31:0] eb;
  bit          ewv, dbusy, rdy, eidle, eacc;
  int          l;
  logic [31:0] edata;

  always @(negedge CLK) begin
    if (!RST_N) begin
      pend.delete();
      div_seen = 0;
    end
    eb = '0;
    ewv = 0;
    eidle = 1;
    foreach (pend[i]) begin
      if (pend[i].acc < cyc && cyc <= pend[i].wb) eb[pend[i].idx] = 1'b1;
      if (pend[i].wb == cyc) begin
        ewv = 1;
        ew = pend[i];
      end
      if (pend[i].wb >= cyc) eidle = 0;
    end
    dbusy = div_seen && (cyc > div_last) && (cyc < div_last + DIV_LAT);
    if (dbusy) eidle = 0;
    l = lat_of(issue_funct);
    rdy = 1;
    if (l != 0) begin
      foreach (pend[i]) if (pend[i].wb == cyc + l) rdy = 0;
      if (eb[issue_ft] || eb[issue_fd]) rdy = 0;
      if (issue_funct != 6'd6 && eb[issue_fs]) rdy = 0;
      if (issue_funct == 6'd3 && dbusy) rdy = 0;
    end
    eacc = RST_N && issue_valid && rdy && (l != 0);

    check("busy_mask", busy_mask, eb);
    check("idle", 32'(idle), 32'(eidle));
    check("wb_valid", 32'(wb_valid), 32'(ewv));
    if (ewv) begin
      case (ew.src)
        0: edata = add_result;
        1: edata = mul_result;
        2: edata = div_result;
        default: edata = ew.mdat;
      endcase
      check("wb_idx", 32'(wb_idx), 32'(ew.idx));
      check("wb_data", wb_data, edata);
    end
    if (RST_N && issue_valid) begin
      check("issue_ready", 32'(issue_ready), 32'(rdy));
      check("illegal", 32'(illegal), 32'(l == 0));
    end
    check("add_start", 32'(add_start), 32'(eacc && l == ADD_LAT && issue_funct <= 6'd1));
    check("mul_start", 32'(mul_start), 32'(eacc && issue_funct == 6'd2));
    check("div_start", 32'(div_start), 32'(eacc && issue_funct == 6'd3));
    if (eacc && issue_funct <= 6'd1) check("add_sub", 32'(add_sub), 32'(issue_funct[0]));

    if (eacc) begin
      np.acc  = cyc;
      np.wb   = cyc + l;
      np.idx  = issue_fd;
      np.src  = (issue_funct <= 6'd1) ? 0 : (issue_funct == 6'd2) ? 1 : (issue_funct == 6'd3) ? 2 : 3;
      np.mdat = mov_data;
      pend.push_back(np);
      if (issue_funct == 6'd3) begin
        div_seen = 1;
        div_last = cyc;
      end
    end
    keep.delete();
    foreach (pend[i]) if (pend[i].wb > cyc) keep.push_back(pend[i]);
    pend = keep;
  end

  // Present an op from posedge+1 until accepted; returns at the next posedge+1.
  task automatic do_issue(input logic [5:0] f, input logic [4:0] fs, input logic [4:0] ft,
                          input logic [4:0] fd, input logic [31:0] md,
                          output int acc, output logic ill);
    issue_valid = 1'b1;
    issue_funct = f;
    issue_fs = fs;
    issue_ft = ft;
    issue_fd = fd;
    mov_data = md;
    acc = -1;
    ill = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (issue_ready) begin
        acc = cyc;
        ill = illegal;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (acc < 0) check("issue_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (idle) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  int   ta, tb;
  logic il;

  initial begin
    RST_N = 1'b0;
    issue_valid = 1'b0;
    issue_funct = '0;
    issue_fs = '0;
    issue_ft = '0;
    issue_fd = '0;
    mov_data = '0;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge CLK);
    #1;

    // ADD fs1 ft2 fd3: busy[3] for cycles +1..+3, writeback at +3.
    do_issue(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, ta, il);
    @(negedge CLK);
    check("add_busy_c1", busy_mask, 32'h0000_0008);
    @(negedge CLK);
    @(negedge CLK);
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_idx", 32'(wb_idx), 32'd3);
    check("add_wb_data", wb_data, 32'hA000_0000 + 32'(ta + 3));
    @(negedge CLK);
    check("add_busy_c4", busy_mask, 32'd0);
    @(posedge CLK);
    #1;
    wait_idle();

    // MUL then ADD: independent, back to back.
    do_issue(6'd2, 5'd1, 5'd2, 5'd4, 32'd0, ta, il);
    do_issue(6'd0, 5'd1, 5'd2, 5'd5, 32'd0, tb, il);
    check("mul_add_gap", 32'(tb - ta), 32'd1);
    wait_idle();

    // SUB then MUL: MUL's writeback would land on SUB's, so it slips one cycle.
    do_issue(6'd1, 5'd1, 5'd2, 5'd20, 32'd0, ta, il);
    do_issue(6'd2, 5'd1, 5'd2, 5'd21, 32'd0, tb, il);
    check("port_conflict_gap", 32'(tb - ta), 32'd2);
    wait_idle();

    // DIV fd6 then ADD reading f6: accepted 13 cycles after the DIV.
    do_issue(6'd3, 5'd8, 5'd9, 5'd6, 32'd0, ta, il);
    do_issue(6'd0, 5'd6, 5'd10, 5'd11, 32'd0, tb, il);
    check("div_raw_gap", 32'(tb - ta), 32'd13);
    wait_idle();

    // Two independent DIVs: fdiv is not pipelined.
    do_issue(6'd3, 5'd13, 5'd14, 5'd12, 32'd0, ta, il);
    do_issue(6'd3, 5'd16, 5'd17, 5'd15, 32'd0, tb, il);
    check("div_div_gap", 32'(tb - ta), 32'd12);
    wait_idle();

    // MOV ft7 -> fd8 writes back next cycle; then an unsupported funct.
    do_issue(6'd6, 5'd0, 5'd7, 5'd8, 32'h3f80_0000, ta, il);
    @(negedge CLK);
    check("mov_wb_valid", 32'(wb_valid), 32'd1);
    check("mov_wb_idx", 32'(wb_idx), 32'd8);
    check("mov_wb_data", wb_data, 32'h3f80_0000);
    @(posedge CLK);
    #1;
    wait_idle();
    do_issue(6'b000101, 5'd1, 5'd2, 5'd9, 32'd0, ta, il);
    check("illegal_pulse", 32'(il), 32'd1);
    @(negedge CLK);
    check("illegal_once", 32'(illegal), 32'd0);
    check("illegal_no_wb", 32'(wb_valid), 32'd0);
    check("illegal_idle", 32'(idle), 32'd1);
    @(posedge CLK);
    #1;

    // Reset five cycles into a DIV discards it.
    do_issue(6'd3, 5'd1, 5'd2, 5'd22, 32'd0, ta, il);
    repeat (4) @(posedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_busy", busy_mask, 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge CLK);
      check("postrst_no_wb", 32'(wb_valid), 32'd0);
    end
    check("postrst_idle", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
